// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc: polyphonic MIDI voice allocator whose outputs are held NOTE_HOLD cycles for a slower-domain sampler.
// Define SUSTAIN_EN to add sustain-pedal handling (per-voice sus bits, release on pedal falling edge).
module midi_voice_alloc #(
   parameter int VOICES    = 8,
   parameter int V_WIDTH   = 3,
   parameter int NOTE_HOLD = 64
) (
   input  logic               sysclk,
   input  logic               reset,
   input  logic               ev_valid,
   output logic               ev_ready,
   input  logic               ev_is_on,
   input  logic [6:0]         ev_key,
   input  logic [6:0]         ev_vel,
   input  logic               sustain,
   output logic               note_on,
   output logic [V_WIDTH-1:0] cur_key_adr,
   output logic [7:0]         cur_key_val,
   output logic [7:0]         cur_vel_on,
   output logic [VOICES-1:0]  keys_on
);
   typedef enum logic [1:0] {IDLE, SCAN, APPLY, HOLD} state_t;
   localparam int HW = $clog2(NOTE_HOLD);

   state_t             state;
   logic [6:0]         voice_key [VOICES];
   logic [V_WIDTH-1:0] steal_ptr;
   logic [V_WIDTH-1:0] scan_idx;
   logic [V_WIDTH-1:0] m_idx;
   logic [V_WIDTH-1:0] f_idx;
   logic               m_found;
   logic               f_found;
   logic               cap_on;
   logic [6:0]         cap_key;
   logic [6:0]         cap_vel;
   logic [HW-1:0]      cnt;
   logic               rdy_q;
   logic               hold_sus;
   logic               steal;
   logic [V_WIDTH-1:0] target;

   assign steal  = !m_found && !f_found;
   assign target = m_found ? m_idx : f_found ? f_idx : steal_ptr;

`ifdef SUSTAIN_EN
   logic [VOICES-1:0] sus;
   logic              sus_q;
   logic              pend;
   assign hold_sus = sustain;
   assign ev_ready = rdy_q & ~pend;
`else
   // Pedal input is accepted but has no effect in this build.
   assign hold_sus = sustain & 1'b0;
   assign ev_ready = rdy_q;
`endif

   always_ff @(posedge sysclk) begin
      if (reset) begin
         state       <= IDLE;
         rdy_q       <= 1'b0;
         note_on     <= 1'b0;
         cur_key_adr <= '0;
         cur_key_val <= '0;
         cur_vel_on  <= '0;
         keys_on     <= '0;
         steal_ptr   <= '0;
         scan_idx    <= '0;
         m_idx       <= '0;
         f_idx       <= '0;
         m_found     <= 1'b0;
         f_found     <= 1'b0;
         cap_on      <= 1'b0;
         cap_key     <= '0;
         cap_vel     <= '0;
         cnt         <= '0;
         for (int v = 0; v < VOICES; v++) voice_key[v] <= '0;
`ifdef SUSTAIN_EN
         sus         <= '0;
         sus_q       <= 1'b0;
         pend        <= 1'b0;
`endif
      end else begin
`ifdef SUSTAIN_EN
         sus_q <= sustain;
         // A pedal release arriving while busy stays pending until the next IDLE cycle.
         pend  <= (sus_q & ~sustain) | (pend & (state != IDLE));
`endif
         case (state)
            IDLE: begin
`ifdef SUSTAIN_EN
               if (pend) begin
                  keys_on <= keys_on & ~sus;
                  sus     <= '0;
                  rdy_q   <= 1'b0;
                  cnt     <= '0;
                  state   <= HOLD;
               end else
`endif
               begin
                  rdy_q <= 1'b1;
                  if (ev_valid && ev_ready) begin
                     cap_on   <= ev_is_on && (|ev_vel);
                     cap_key  <= ev_key;
                     cap_vel  <= ev_vel;
                     scan_idx <= '0;
                     m_found  <= 1'b0;
                     f_found  <= 1'b0;
                     rdy_q    <= 1'b0;
                     state    <= SCAN;
                  end
               end
            end
            SCAN: begin
               if (!m_found && keys_on[scan_idx] && voice_key[scan_idx] == cap_key) begin
                  m_found <= 1'b1;
                  m_idx   <= scan_idx;
               end
               if (!f_found && !keys_on[scan_idx]) begin
                  f_found <= 1'b1;
                  f_idx   <= scan_idx;
               end
               scan_idx <= scan_idx + 1'b1;
               if (scan_idx == V_WIDTH'(VOICES - 1)) state <= APPLY;
            end
            APPLY: begin
               cnt <= '0;
               if (cap_on) begin
                  voice_key[target] <= cap_key;
                  keys_on[target]   <= 1'b1;
                  cur_key_adr       <= target;
                  cur_key_val       <= {1'b0, cap_key};
                  cur_vel_on        <= {1'b0, cap_vel};
                  note_on           <= 1'b1;
                  state             <= HOLD;
                  if (steal) steal_ptr <= steal_ptr + 1'b1;
`ifdef SUSTAIN_EN
                  sus[target]       <= 1'b0;
`endif
               end else if (m_found && !hold_sus) begin
                  keys_on[m_idx] <= 1'b0;
                  cur_key_adr    <= m_idx;
                  cur_key_val    <= {1'b0, cap_key};
                  state          <= HOLD;
               end else begin
`ifdef SUSTAIN_EN
                  if (m_found) sus[m_idx] <= 1'b1;
`endif
                  state <= IDLE;
               end
            end
            HOLD: begin
               if (cnt == HW'(NOTE_HOLD - 1)) begin
                  note_on <= 1'b0;
                  rdy_q   <= 1'b1;
                  state   <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_midi_voice_alloc.sv
// tb_midi_voice_alloc: vector table of note events with a scoreboard of expected held outputs.
module tb_midi_voice_alloc;
   logic       sysclk = 1'b0;
   logic       reset = 1'b1;
   logic       ev_valid = 1'b0;
   logic       ev_is_on = 1'b0;
   logic       sustain = 1'b0;
   logic [6:0] ev_key = '0;
   logic [6:0] ev_vel = '0;
   logic       ev_ready;
   logic       note_on;
   logic [2:0] cur_key_adr;
   logic [7:0] cur_key_val;
   logic [7:0] cur_vel_on;
   logic [7:0] keys_on;
   int checks = 0;
   int errors = 0;

   always #5 sysclk = ~sysclk;

   midi_voice_alloc #(.VOICES(8), .V_WIDTH(3), .NOTE_HOLD(64)) dut (
      .sysclk(sysclk), .reset(reset), .ev_valid(ev_valid), .ev_ready(ev_ready),
      .ev_is_on(ev_is_on), .ev_key(ev_key), .ev_vel(ev_vel), .sustain(sustain),
      .note_on(note_on), .cur_key_adr(cur_key_adr), .cur_key_val(cur_key_val),
      .cur_vel_on(cur_vel_on), .keys_on(keys_on)
   );

   typedef struct {
      logic       is_on;
      logic [6:0] key;
      logic [6:0] vel;
      logic [2:0] adr;
      logic [7:0] kval;
      logic [7:0] velo;
      logic [7:0] kon;
      logic       non;
      logic       hold;
   } vec_t;

   vec_t tbl[21];
   vec_t sb[$];

   function automatic vec_t mk(logic o, logic [6:0] k, logic [6:0] v, logic [2:0] a,
                               logic [7:0] kv, logic [7:0] vo, logic [7:0] ko, logic n, logic h);
      vec_t r;
      r.is_on = o; r.key = k; r.vel = v; r.adr = a; r.kval = kv;
      r.velo = vo; r.kon = ko; r.non = n; r.hold = h;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic handshake(input logic o, input logic [6:0] k, input logic [6:0] v, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge sysclk);
         if (ev_ready === 1'b1) ok = 1'b1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout got=0 want=1 t=%0t", $time);
         return;
      end
      ev_valid = 1'b1; ev_is_on = o; ev_key = k; ev_vel = v;
      @(posedge sysclk);
      #1 ev_valid = 1'b0;
   endtask

   task automatic run_vec(input vec_t v);
      bit   ok;
      vec_t e;
      handshake(v.is_on, v.key, v.vel, ok);
      if (!ok) return;
      sb.push_back(v);
      step(8);
      chk("pre_note_on", note_on, 0);
      chk("pre_ready", ev_ready, 0);
      step(1);
      e = sb.pop_front();
      chk("adr", cur_key_adr, e.adr);
      chk("key_val", cur_key_val, e.kval);
      chk("vel_on", cur_vel_on, e.velo);
      chk("keys_on", keys_on, e.kon);
      chk("note_on", note_on, e.non);
      chk("apply_ready", ev_ready, 0);
      if (e.hold) begin
         step(63);
         chk("hold_end_note_on", note_on, e.non);
         chk("hold_end_ready", ev_ready, 0);
         step(1);
         chk("release_ready", ev_ready, 1);
         chk("release_note_on", note_on, 0);
      end else begin
         step(1);
         chk("skip_ready", ev_ready, 1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   initial begin
      bit ok;
      tbl[0]  = mk(1, 60, 100, 0, 60, 100, 8'h01, 1, 1);
      tbl[1]  = mk(1, 61, 10,  1, 61, 10,  8'h03, 1, 1);
      tbl[2]  = mk(1, 62, 62,  2, 62, 62,  8'h07, 1, 1);
      tbl[3]  = mk(1, 63, 63,  3, 63, 63,  8'h0F, 1, 1);
      tbl[4]  = mk(1, 64, 64,  4, 64, 64,  8'h1F, 1, 1);
      tbl[5]  = mk(1, 65, 65,  5, 65, 65,  8'h3F, 1, 1);
      tbl[6]  = mk(1, 66, 66,  6, 66, 66,  8'h7F, 1, 1);
      tbl[7]  = mk(1, 67, 67,  7, 67, 67,  8'hFF, 1, 1);
      tbl[8]  = mk(1, 68, 90,  0, 68, 90,  8'hFF, 1, 1);
      tbl[9]  = mk(1, 68, 30,  0, 68, 30,  8'hFF, 1, 1);
      tbl[10] = mk(1, 69, 40,  1, 69, 40,  8'hFF, 1, 1);
      tbl[11] = mk(1, 68, 0,   0, 68, 40,  8'hFE, 0, 1);
      tbl[12] = mk(0, 99, 0,   0, 68, 40,  8'hFE, 0, 0);
      tbl[13] = mk(1, 70, 5,   0, 70, 5,   8'hFF, 1, 1);
      tbl[14] = mk(0, 63, 0,   3, 63, 5,   8'hF7, 0, 1);
      tbl[15] = mk(0, 62, 77,  2, 62, 5,   8'hF3, 0, 1);
      tbl[16] = mk(1, 71, 1,   2, 71, 1,   8'hF7, 1, 1);
      tbl[17] = mk(1, 72, 127, 3, 72, 127, 8'hFF, 1, 1);
      tbl[18] = mk(1, 73, 9,   2, 73, 9,   8'hFF, 1, 1);
      tbl[19] = mk(0, 73, 0,   2, 73, 9,   8'hFB, 0, 1);
      tbl[20] = mk(1, 69, 50,  1, 69, 50,  8'hFB, 1, 1);

      step(3);
      chk("rst_note_on", note_on, 0);
      chk("rst_adr", cur_key_adr, 0);
      chk("rst_key_val", cur_key_val, 0);
      chk("rst_vel_on", cur_vel_on, 0);
      chk("rst_keys_on", keys_on, 0);
      chk("rst_ready", ev_ready, 0);
      @(negedge sysclk) reset = 1'b0;
      step(1);
      chk("post_rst_ready", ev_ready, 1);

      for (int i = 0; i < 21; i++) run_vec(tbl[i]);

      // Reset in the middle of a hold window.
      handshake(1, 80, 50, ok);
      if (ok) begin
         step(20);
         chk("hold_note_on", note_on, 1);
         chk("hold_adr", cur_key_adr, 2);
         @(negedge sysclk) reset = 1'b1;
         step(1);
         chk("midrst_note_on", note_on, 0);
         chk("midrst_adr", cur_key_adr, 0);
         chk("midrst_key_val", cur_key_val, 0);
         chk("midrst_vel_on", cur_vel_on, 0);
         chk("midrst_keys_on", keys_on, 0);
         chk("midrst_ready", ev_ready, 0);
         @(negedge sysclk) reset = 1'b0;
         step(1);
         chk("midrst_ready_after", ev_ready, 1);
      end
      run_vec(mk(1, 60, 100, 0, 60, 100, 8'h01, 1, 1));

`ifdef SUSTAIN_EN
      sustain = 1'b1;
      run_vec(mk(0, 60, 0, 0, 60, 100, 8'h01, 0, 0));
      @(negedge sysclk) sustain = 1'b0;
      step(2);
      chk("sus_keys_on", keys_on, 0);
      chk("sus_note_on", note_on, 0);
      chk("sus_key_val", cur_key_val, 60);
      chk("sus_ready", ev_ready, 0);
      step(63);
      chk("sus_hold_ready", ev_ready, 0);
      step(1);
      chk("sus_release_ready", ev_ready, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
